// File: rtl/ahb_ram_responder.sv
// rtl/ahb_ram_responder.sv - AHB-Lite RAM responder with address parity and SEC-DED data checking
// Bad address phases and uncorrectable write data answer with a two-cycle ERROR.
module ahb_ram_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic        s_hsel_i,
  input  logic [31:0] s_haddr_i,
  input  logic [1:0]  s_htrans_i,
  input  logic        s_hwrite_i,
  input  logic [2:0]  s_hsize_i,
  input  logic [2:0]  s_hburst_i,
  input  logic [3:0]  s_hprot_i,
  input  logic        s_hmastlock_i,
  input  logic [5:0]  s_hparity_i,
  input  logic [31:0] s_hwdata_i,
  input  logic [6:0]  s_hwchecksum_i,
  input  logic        s_hready_i,
  output logic [31:0] s_hrdata_o,
  output logic [6:0]  s_hrchecksum_o,
  output logic        s_hreadyout_o,
  output logic        s_hresp_o,
  output logic [7:0]  s_err_cnt_o,
  output logic [7:0]  s_fix_cnt_o
);
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR2} state_t;

  // Hamming over codeword positions 1..38 (check bits at powers of two) plus overall parity in bit 6.
  function automatic logic [6:0] secded_enc(input logic [31:0] d);
    logic [5:0] syn;
    int         k;
    syn = '0;
    k   = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k[4:0]]) syn = syn ^ 6'(p);
        k++;
      end
    end
    return {(^d) ^ (^syn), syn};
  endfunction

  // Returns {uncorrectable, single_error, corrected_data}.
  function automatic logic [33:0] secded_dec(input logic [31:0] d, input logic [6:0] c);
    logic [6:0]  e;
    logic [5:0]  syn;
    logic [31:0] fixed;
    logic        par;
    int          k;
    e     = secded_enc(d);
    syn   = e[5:0] ^ c[5:0];
    par   = ^{d, c};
    fixed = d;
    k     = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (par && (syn == 6'(p))) fixed[k[4:0]] = ~d[k[4:0]];
        k++;
      end
    end
    return {(!par && (syn != 6'd0)) || (par && (syn > 6'd38)), par && (syn <= 6'd38), fixed};
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          active_q, bad_q, write_q;
  logic [AW+1:0] addr_q;
  logic [2:0]    size_q;
  logic [31:0]   rdata_q;
  logic [7:0]    err_cnt_q, err_cnt_d, fix_cnt_q, fix_cnt_d;
  logic [31:0]   mem_q [DEPTH];

  logic [5:0]    par_exp;
  logic [32:0]   offset;
  logic          accept, bad_addr;
  logic [33:0]   dec;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_rd, wr_word;
  logic [3:0]    byte_en;
  logic          hready_out, hresp_out, complete, mem_we, rd_done, err_inc, fix_inc;

  always_comb begin
    par_exp = {^{s_hburst_i, s_hprot_i, s_hmastlock_i}, ^{s_htrans_i, s_hwrite_i, s_hsize_i},
               ^s_haddr_i[31:24], ^s_haddr_i[23:16], ^s_haddr_i[15:8], ^s_haddr_i[7:0]};
  end

  // Addresses below BASE_ADDR wrap to a huge offset and fail the same span test.
  assign offset   = {1'b0, s_haddr_i} - {1'b0, BASE_ADDR};
  assign accept   = s_hsel_i & s_hready_i & s_htrans_i[1];
  assign bad_addr = (par_exp != s_hparity_i) | (s_hsize_i > 3'd2)
                  | ((s_hsize_i == 3'd1) & s_haddr_i[0])
                  | ((s_hsize_i == 3'd2) & (|s_haddr_i[1:0]))
                  | (offset >= SPAN);

  assign dec      = secded_dec(s_hwdata_i, s_hwchecksum_i);
  assign word_idx = addr_q[AW+1:2];
  assign mem_rd   = mem_q[word_idx];

  always_comb begin
    case (size_q)
      3'd0:    byte_en = 4'b0001 << addr_q[1:0];
      3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
    wr_word = mem_rd;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) wr_word[8*b +: 8] = dec[8*b +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hready_out = 1'b1;
    hresp_out  = 1'b0;
    complete   = 1'b0;
    mem_we     = 1'b0;
    rd_done    = 1'b0;
    err_inc    = 1'b0;
    fix_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (active_q) begin
          if (bad_q) begin
            hready_out = 1'b0;
            hresp_out  = 1'b1;
            err_inc    = 1'b1;
            state_d    = ST_ERR2;
          end else if (WAIT_STATES != 0) begin
            hready_out = 1'b0;
            cnt_d      = WAIT_LOAD;
            state_d    = ST_WAIT;
          end else begin
            complete = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          hready_out = 1'b0;
          cnt_d      = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
        end
      end
      ST_ERR2: begin
        hresp_out = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (complete) begin
      state_d = ST_IDLE;
      if (write_q && dec[33]) begin
        hready_out = 1'b0;
        hresp_out  = 1'b1;
        err_inc    = 1'b1;
        state_d    = ST_ERR2;
      end else if (write_q) begin
        mem_we  = 1'b1;
        fix_inc = dec[32];
      end else begin
        rd_done = 1'b1;
      end
    end
    err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    fix_cnt_d = (fix_inc && (fix_cnt_q != 8'hFF)) ? fix_cnt_q + 8'd1 : fix_cnt_q;
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      active_q  <= 1'b0;
      bad_q     <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      rdata_q   <= '0;
      err_cnt_q <= '0;
      fix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= s_hrdata_o;
      err_cnt_q <= err_cnt_d;
      fix_cnt_q <= fix_cnt_d;
      if (s_hready_i) begin
        active_q <= accept;
        if (accept) begin
          bad_q   <= bad_addr;
          write_q <= s_hwrite_i;
          addr_q  <= s_haddr_i[AW+1:0];
          size_q  <= s_hsize_i;
        end
      end
    end
  end

  // Array is deliberately not reset; writes only fire on a completing data cycle.
  always_ff @(posedge s_clk_i) begin
    if (mem_we) mem_q[word_idx] <= wr_word;
  end

  assign s_hrdata_o     = rd_done ? mem_rd : rdata_q;
  assign s_hrchecksum_o = secded_enc(s_hrdata_o);
  assign s_hreadyout_o  = hready_out;
  assign s_hresp_o      = hresp_out;
  assign s_err_cnt_o    = err_cnt_q;
  assign s_fix_cnt_o    = fix_cnt_q;
endmodule

// File: doc/ahb_ram_responder.md
Name: ahb_ram_responder

Overview:
- AHB-Lite subordinate (responder) memory that sits at the far end of the core's instruction or data bus.
- Checks the custom 6-bit address-phase parity the core emits.
- Corrects or rejects write data using the 7-bit write checksum.
- Returns read data with a 7-bit read checksum.
- Used as on-chip RAM/ROM in the system top and testbenches; optional wait-state insertion exercises the core's stall paths.

Parameters:
- DEPTH, 1024, number of 32-bit words (power of two, ≥ 4).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH*4-aligned).
- WAIT_STATES, 0, wait cycles (hreadyout=0) inserted before every OKAY completion; range 0..15.

Ports:
- s_clk_i  in  1  clock.
- s_reset_i  in  1  asynchronous active-high reset.
- s_hsel_i  in  1  slave select.
- s_haddr_i  in  32  address.
- s_htrans_i  in  2  transfer type.
- s_hwrite_i  in  1  write indicator.
- s_hsize_i  in  3  transfer size.
- s_hburst_i  in  3  burst type (parity only).
- s_hprot_i  in  4  protection (parity only).
- s_hmastlock_i  in  1  lock (parity only).
- s_hparity_i  in  6  address-phase parity.
- s_hwdata_i  in  32  write data.
- s_hwchecksum_i  in  7  write-data SEC-DED checksum.
- s_hready_i  in  1  bus HREADY (previous transfer complete).
- s_hrdata_o  out  32  read data.
- s_hrchecksum_o  out  7  SEC-DED checksum of s_hrdata_o.
- s_hreadyout_o  out  1  transfer-complete.
- s_hresp_o  out  1  0 = OKAY, 1 = ERROR.
- s_err_cnt_o  out  8  saturating count of ERROR responses.
- s_fix_cnt_o  out  8  saturating count of corrected write-data single-bit errors.

Behaviour:
- Reset:
  - hreadyout=1, hresp=0, hrdata=0, hrchecksum=enc(0), counters=0, FSM=IDLE.
  - Memory contents are not reset.
  - Reset asserted mid-transfer abandons it; no partial write occurs.
- Address phase accepted when hsel & hready_i & htrans[1] (NONSEQ/SEQ). It latches addr, write, size.
- IDLE/BUSY or hsel=0 with hready_i=1: next cycle is zero-wait OKAY, no access.
- Parity (even parity, bit = XOR of its group):
  - p[i] = ^haddr[8i+7:8i] for i = 0..3.
  - p[4] = ^{htrans, hwrite, hsize}.
  - p[5] = ^{hburst, hprot, hmastlock}.
- An accepted transfer is flagged bad if any of the following holds:
  - parity mismatch;
  - hsize > 2;
  - address misaligned to hsize;
  - address outside [BASE_ADDR, BASE_ADDR+4*DEPTH).
- FSM states IDLE, WAIT, ERR2.
  - IDLE, accepted bad transfer: drive hreadyout=0, hresp=1 in the first data cycle, then go to ERR2. ERR2 drives hreadyout=1, hresp=1, then returns to IDLE or accepts the next transfer.
  - IDLE, accepted good transfer, WAIT_STATES>0: load the counter and go to WAIT with hreadyout=0, hresp=0. Stay for WAIT_STATES cycles, then complete with hreadyout=1.
  - WAIT_STATES=0: the good transfer completes in the first data cycle.
- Read completion:
  - hrdata = mem[word], combinational from the array, so a read immediately after a write to the same word returns the new value.
  - hrchecksum = enc(hrdata) using the shared 7-bit SEC-DED encoder.
- Write, evaluated in the completing data cycle:
  - Decode {hwdata, hwchecksum}.
  - No error: write the byte lanes selected by size/addr[1:0].
  - Single-bit error: write the corrected data and increment fix_cnt.
  - Uncorrectable error: no write; the cycle becomes ERROR cycle 1 (hreadyout=0, hresp=1), then ERR2.
- Every ERROR response increments err_cnt once. Both counters saturate at 255.
- A new address phase presented during ERR2 or on the completing cycle is accepted (pipelined back-to-back). During WAIT and ERROR cycle 1, hready_i=0 blocks acceptance.
- hrdata holds its last value on writes and errors.

Test Plan:
- Reset, then back-to-back NONSEQ word write 0xDEADBEEF @0x10 and read @0x10, WAIT_STATES=0 -> both complete zero-wait OKAY; read returns 0xDEADBEEF with hrchecksum=enc(0xDEADBEEF).
- Byte write 0xAA to 0x13 over word 0x11223344 -> read of 0x10 returns 0xAA223344; halfword write to 0x11 -> two-cycle ERROR, err_cnt=1, memory unchanged.
- Address phase with p[0] flipped -> hreadyout 0/1 with hresp 1/1 over two cycles; no write; err_cnt increments.
- Write with hwdata bit 5 flipped vs checksum -> corrected value stored, OKAY, fix_cnt=1. Two bits flipped -> ERROR, no write.
- WAIT_STATES=3, read -> hreadyout low for exactly 3 cycles, OKAY on the 4th data cycle.
- Reset asserted during a WAIT cycle of a write -> hreadyout=1, hresp=0 next edge; target word unchanged; err_cnt=0. Address outside the range (BASE_ADDR+4*DEPTH) -> ERROR.
